// File: rtl/tcam_mem.sv
// Ternary CAM routing memory for a spike router: address-based write/read of data,
// care and valid arrays, plus associative compare (full key) and fire (source ID) search.
module tcam_mem #(
  parameter int ID_Width    = 4,
  parameter int AddressSize = 4,
  parameter int Bits        = 8,
  parameter int Words       = 16,
  parameter int BankSize    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             MODE,
  input  logic [ID_Width-1:0]    PacketID_In,
  input  logic [Bits-1:0]        Data_In,
  input  logic [Bits-1:0]        Mskb_In,
  input  logic [AddressSize-1:0] A_In,
  input  logic                   Dcs_In,
  input  logic                   Vbe_In,
  input  logic                   Vbi_In,
  output logic [ID_Width-1:0]    DstID_Out,
  output logic [Bits-1:0]        Data_Out,
  output logic                   Vb_Out,
  output logic                   Hit_Out,
  output logic [Words-1:0]       Hitline_Out
);

  typedef enum logic [2:0] {
    OP_IDLE  = 3'b000,
    OP_WRITE = 3'b001,
    OP_READ  = 3'b010,
    OP_FIRE  = 3'b011,
    OP_CMP   = 3'b100,
    OP_CLR   = 3'b101
  } op_e;

  localparam int WORDS_PER_BANK = Words / BankSize;
  // Fire keys only on the source-ID field; everything below it is excluded.
  localparam logic [Bits-1:0] FIRE_IGN = {{ID_Width{1'b0}}, {(Bits-ID_Width){1'b1}}};

  logic [Bits-1:0]     data_q [Words];
  logic [Bits-1:0]     data_d [Words];
  logic [Bits-1:0]     care_q [Words];
  logic [Bits-1:0]     care_d [Words];
  logic [Words-1:0]    valid_q, valid_d;
  logic [ID_Width-1:0] dst_q, dst_d;
  logic [Bits-1:0]     rdata_q, rdata_d;
  logic                vb_q, vb_d;
  logic                hit_q, hit_d;
  logic [Words-1:0]    hitline_q, hitline_d;

  logic [Words-1:0]    cmp_match, fire_match;
  logic [ID_Width-1:0] fire_dst;
  logic                addr_ok;
  logic [Bits-1:0]     fire_key;

  function automatic logic [Bits-1:0] masked_merge(logic [Bits-1:0] old_v,
                                                   logic [Bits-1:0] new_v,
                                                   logic [Bits-1:0] keep);
    return (old_v & keep) | (new_v & ~keep);
  endfunction

  function automatic logic entry_match(logic v, logic [Bits-1:0] d, logic [Bits-1:0] c,
                                       logic [Bits-1:0] key, logic [Bits-1:0] ign);
    return v && ((c & ~ign & (d ^ key)) == '0);
  endfunction

  assign addr_ok  = (int'(A_In) < Words);
  assign fire_key = {PacketID_In, {(Bits-ID_Width){1'b0}}};

  // Search: every bank evaluates every entry in parallel.
  always_comb begin
    cmp_match  = '0;
    fire_match = '0;
    for (int b = 0; b < BankSize; b++) begin
      for (int w = 0; w < WORDS_PER_BANK; w++) begin
        int idx;
        idx = b * WORDS_PER_BANK + w;
        cmp_match[idx]  = entry_match(valid_q[idx], data_q[idx], care_q[idx], Data_In, Mskb_In);
        fire_match[idx] = entry_match(valid_q[idx], data_q[idx], care_q[idx], fire_key, FIRE_IGN);
      end
    end
  end

  // Lowest matching index wins the destination.
  always_comb begin
    fire_dst = '0;
    for (int k = Words - 1; k >= 0; k--) begin
      if (fire_match[k]) fire_dst = data_q[k][ID_Width-1:0];
    end
  end

  always_comb begin
    data_d    = data_q;
    care_d    = care_q;
    valid_d   = valid_q;
    dst_d     = dst_q;
    rdata_d   = rdata_q;
    vb_d      = vb_q;
    hit_d     = hit_q;
    hitline_d = hitline_q;
    case (MODE)
      OP_WRITE: begin
        if (addr_ok) begin
          if (Dcs_In) data_d[A_In] = masked_merge(data_q[A_In], Data_In, Mskb_In);
          else        care_d[A_In] = masked_merge(care_q[A_In], Data_In, Mskb_In);
          if (Vbe_In) valid_d[A_In] = Vbi_In;
        end
      end
      OP_READ: begin
        if (addr_ok) begin
          rdata_d = Dcs_In ? data_q[A_In] : care_q[A_In];
          vb_d    = Vbe_In ? valid_q[A_In] : 1'b0;
        end else begin
          rdata_d = '0;
          vb_d    = 1'b0;
        end
      end
      OP_FIRE: begin
        hitline_d = fire_match;
        hit_d     = |fire_match;
        dst_d     = fire_dst;
      end
      OP_CMP: begin
        hitline_d = cmp_match;
        hit_d     = |cmp_match;
      end
      OP_CLR: begin
        for (int k = 0; k < Words; k++) begin
          data_d[k] = '0;
          care_d[k] = '0;
        end
        valid_d   = '0;
        dst_d     = '0;
        rdata_d   = '0;
        vb_d      = 1'b0;
        hit_d     = 1'b0;
        hitline_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < Words; k++) begin
        data_q[k] <= '0;
        care_q[k] <= '0;
      end
      valid_q   <= '0;
      dst_q     <= '0;
      rdata_q   <= '0;
      vb_q      <= 1'b0;
      hit_q     <= 1'b0;
      hitline_q <= '0;
    end else begin
      for (int k = 0; k < Words; k++) begin
        data_q[k] <= data_d[k];
        care_q[k] <= care_d[k];
      end
      valid_q   <= valid_d;
      dst_q     <= dst_d;
      rdata_q   <= rdata_d;
      vb_q      <= vb_d;
      hit_q     <= hit_d;
      hitline_q <= hitline_d;
    end
  end

  assign DstID_Out   = dst_q;
  assign Data_Out    = rdata_q;
  assign Vb_Out      = vb_q;
  assign Hit_Out     = hit_q;
  assign Hitline_Out = hitline_q;

endmodule

// File: tb/tb_tcam_mem.sv
// Directed bench for tcam_mem: write/read, masked write, compare, fire priority,
// valid-bit gating, sync clear and async reset abort, with hand-computed expectations.
module tb_tcam_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  MODE = 3'b000;
  logic [3:0]  PacketID_In = '0;
  logic [7:0]  Data_In = '0;
  logic [7:0]  Mskb_In = '0;
  logic [3:0]  A_In = '0;
  logic        Dcs_In = 1'b0;
  logic        Vbe_In = 1'b0;
  logic        Vbi_In = 1'b0;
  logic [3:0]  DstID_Out;
  logic [7:0]  Data_Out;
  logic        Vb_Out;
  logic        Hit_Out;
  logic [15:0] Hitline_Out;

  int checks = 0;
  int failures = 0;

  tcam_mem dut (
    .clk(clk), .rst(rst), .MODE(MODE), .PacketID_In(PacketID_In),
    .Data_In(Data_In), .Mskb_In(Mskb_In), .A_In(A_In), .Dcs_In(Dcs_In),
    .Vbe_In(Vbe_In), .Vbi_In(Vbi_In), .DstID_Out(DstID_Out), .Data_Out(Data_Out),
    .Vb_Out(Vb_Out), .Hit_Out(Hit_Out), .Hitline_Out(Hitline_Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation for exactly one rising edge, then return to idle.
  task automatic op(input logic [2:0] m, input logic [7:0] d, input logic [7:0] msk,
                    input logic [3:0] a, input logic [3:0] pid,
                    input logic dcs, input logic vbe, input logic vbi);
    @(negedge clk);
    MODE = m; Data_In = d; Mskb_In = msk; A_In = a; PacketID_In = pid;
    Dcs_In = dcs; Vbe_In = vbe; Vbi_In = vbi;
    @(posedge clk);
    #1;
    MODE = 3'b000;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", Data_Out, 8'h00);
    chk("rst_vb", Vb_Out, 1'b0);
    chk("rst_hit", Hit_Out, 1'b0);
    chk("rst_hitline", Hitline_Out, 16'h0000);
    chk("rst_dst", DstID_Out, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    op(3'b010, 8'h00, 8'h00, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("rd3_data", Data_Out, 8'h00);
    chk("rd3_vb", Vb_Out, 1'b0);
    op(3'b100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("cmp_empty_hit", Hit_Out, 1'b0);
    chk("cmp_empty_hitline", Hitline_Out, 16'h0000);

    op(3'b001, 8'hFF, 8'h00, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    op(3'b001, 8'h5A, 8'h00, 4'd2, 4'd0, 1'b1, 1'b1, 1'b1);
    op(3'b010, 8'h00, 8'h00, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("rd2_data", Data_Out, 8'h5A);
    chk("rd2_vb", Vb_Out, 1'b1);
    op(3'b010, 8'h00, 8'h00, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("rd2_care", Data_Out, 8'hFF);
    chk("rd2_vb_disabled", Vb_Out, 1'b0);
    op(3'b100, 8'h5A, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("cmp5A_hit", Hit_Out, 1'b1);
    chk("cmp5A_hitline", Hitline_Out, 16'h0004);
    op(3'b100, 8'h5B, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("cmp5B_hit", Hit_Out, 1'b0);
    chk("cmp5B_hitline", Hitline_Out, 16'h0000);
    op(3'b100, 8'h5B, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("cmp5B_masked_hitline", Hitline_Out, 16'h0004);

    op(3'b001, 8'hFF, 8'h0F, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    op(3'b010, 8'h00, 8'h00, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("mskwr_data", Data_Out, 8'hFA);
    chk("mskwr_vb_kept", Vb_Out, 1'b1);

    op(3'b001, 8'hF0, 8'h00, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    op(3'b001, 8'h3C, 8'h00, 4'd1, 4'd0, 1'b1, 1'b1, 1'b1);
    op(3'b001, 8'hF0, 8'h00, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0);
    op(3'b001, 8'h37, 8'h00, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1);
    op(3'b011, 8'h00, 8'hFF, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("fire3_hitline", Hitline_Out, 16'h0012);
    chk("fire3_hit", Hit_Out, 1'b1);
    chk("fire3_dst", DstID_Out, 4'hC);
    op(3'b100, 8'hFA, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("cmp_keeps_dst", DstID_Out, 4'hC);
    chk("cmpFA_hitline", Hitline_Out, 16'h0004);
    op(3'b011, 8'h00, 8'h00, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0);
    chk("fire9_hit", Hit_Out, 1'b0);
    chk("fire9_dst", DstID_Out, 4'h0);
    chk("fire9_hitline", Hitline_Out, 16'h0000);

    op(3'b001, 8'h00, 8'hFF, 4'd4, 4'd0, 1'b1, 1'b1, 1'b0);
    op(3'b011, 8'h00, 8'h00, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("fire3_inval_hitline", Hitline_Out, 16'h0002);
    chk("fire3_inval_dst", DstID_Out, 4'hC);

    // Entry 7: care all zero, valid -> matches any key.
    op(3'b001, 8'h95, 8'h00, 4'd7, 4'd0, 1'b1, 1'b1, 1'b1);
    op(3'b011, 8'h00, 8'h00, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0);
    chk("fire9_dc_hitline", Hitline_Out, 16'h0080);
    chk("fire9_dc_dst", DstID_Out, 4'h5);
    op(3'b011, 8'h00, 8'h00, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("fire3_prio_hitline", Hitline_Out, 16'h0082);
    chk("fire3_prio_dst", DstID_Out, 4'hC);

    op(3'b101, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("clr_dst", DstID_Out, 4'h0);
    chk("clr_hit", Hit_Out, 1'b0);
    op(3'b100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("clr_cmp_hitline", Hitline_Out, 16'h0000);
    for (int a = 1; a < 8; a += 3) begin
      op(3'b010, 8'h00, 8'h00, 4'(a), 4'd0, 1'b1, 1'b1, 1'b0);
      chk("clr_rd_data", Data_Out, 8'h00);
      chk("clr_rd_vb", Vb_Out, 1'b0);
    end
    op(3'b010, 8'h00, 8'h00, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("clr_rd_care", Data_Out, 8'h00);

    op(3'b001, 8'h77, 8'h00, 4'd5, 4'd0, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    #5;
    rst = 1'b0;
    op(3'b010, 8'h00, 8'h00, 4'd5, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("rstpulse_data", Data_Out, 8'h00);
    chk("rstpulse_vb", Vb_Out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
